uart_rx_frame_ctrl: RTL and testbench

//  Sequences the UART receive byte stream into checked command frames.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_frame_buf.sv | 17 +
 rtl/uart_rx_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared states, error codes and the default frame header for the UART frame controller
package uart_pkg;
  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, OUT} state_t;
  localparam logic [2:0] ERR_BAD_LEN  = 3'd1;
  localparam logic [2:0] ERR_BAD_CSUM = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_OVERRUN  = 3'd4;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload store with synchronous write and combinational read
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses [HDR][LEN][PAYLOAD][CSUM] from UART bytes and releases checked payloads
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rx_done,
  input  logic [7:0]               i_rx_data,
  output logic                     o_frm_valid,
  input  logic                     i_frm_ready,
  output logic [7:0]               o_frm_data,
  output logic                     o_frm_last,
  output logic [$clog2(MAX_LEN):0] o_frm_len,
  output logic                     o_err_pulse,
  output logic [2:0]               o_err_code,
  output logic                     o_busy
);
  localparam int PW = $clog2(MAX_LEN) + 1;
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  state_t          r_state, w_state_nx;
  logic            r_rx_q;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, r_frm_len;
  logic [7:0]      r_csum;
  logic [TW-1:0]   r_to_cnt;
  logic            r_err_pulse;
  logic [2:0]      r_err_code;
  logic            w_acc, w_hs, w_last, w_wr_last, w_len_ok, w_csum_ok, w_timing, w_to_exp, w_err;
  logic [2:0]      w_err_code;
  logic [7:0]      w_rdata;
  assign w_acc     = i_rx_done & ~r_rx_q;
  assign w_hs      = o_frm_valid & i_frm_ready;
  assign w_last    = r_rd_ptr == r_frm_len - PW'(1);
  assign w_wr_last = r_wr_ptr == r_frm_len - PW'(1);
  assign w_len_ok  = (i_rx_data != 8'd0) && (i_rx_data <= MAX_B);
  assign w_csum_ok = i_rx_data == r_csum;
  assign w_timing  = r_state inside {LEN, PAYLOAD, CSUM};
  // expires on the edge where the count would reach TIMEOUT_CYC-1; a same-cycle accept wins
  assign w_to_exp  = w_timing & ~w_acc & (r_to_cnt == TW'(TIMEOUT_CYC - 2));
  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(IW)) u_buf (
    .clk     (clk),
    .i_we    (r_state == PAYLOAD && w_acc),
    .i_waddr (r_wr_ptr[IW-1:0]),
    .i_wdata (i_rx_data),
    .i_raddr (r_rd_ptr[IW-1:0]),
    .o_rdata (w_rdata)
  );
  always_comb begin
    w_state_nx = r_state;
    w_err      = 1'b0;
    w_err_code = r_err_code;
    if (w_to_exp) begin
      w_state_nx = IDLE;
      w_err      = 1'b1;
      w_err_code = ERR_TIMEOUT;
    end else begin
      case (r_state)
        IDLE: w_state_nx = (w_acc && i_rx_data == HDR_BYTE) ? LEN : IDLE;
        LEN: if (w_acc) begin
          w_state_nx = w_len_ok ? PAYLOAD : IDLE;
          w_err      = ~w_len_ok;
          w_err_code = ERR_BAD_LEN;
        end
        PAYLOAD: w_state_nx = (w_acc && w_wr_last) ? CSUM : PAYLOAD;
        CSUM: if (w_acc) begin
          w_state_nx = w_csum_ok ? OUT : IDLE;
          w_err      = ~w_csum_ok;
          w_err_code = ERR_BAD_CSUM;
        end
        OUT: begin
          w_err      = w_acc;
          w_err_code = ERR_OVERRUN;
          w_state_nx = (w_hs && w_last) ? IDLE : OUT;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rx_q      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_frm_len   <= '0;
      r_csum      <= '0;
      r_to_cnt    <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_rx_q      <= i_rx_done;
      r_err_pulse <= w_err;
      r_err_code  <= w_err ? w_err_code : r_err_code;
      r_to_cnt    <= w_acc ? '0 : w_timing ? r_to_cnt + TW'(1) : r_to_cnt;
      if (r_state == LEN && w_acc && w_len_ok) begin
        r_frm_len <= i_rx_data[PW-1:0];
        r_csum    <= i_rx_data;
        r_wr_ptr  <= '0;
      end
      if (r_state == PAYLOAD && w_acc) begin
        r_csum   <= r_csum ^ i_rx_data;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (r_state == CSUM && w_acc) r_rd_ptr <= '0;
      else if (w_hs) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end
  assign o_frm_valid = r_state == OUT;
  assign o_frm_data  = o_frm_valid ? w_rdata : 8'd0;
  assign o_frm_last  = o_frm_valid & w_last;
  assign o_frm_len   = r_frm_len;
  assign o_err_pulse = r_err_pulse;
  assign o_err_code  = r_err_code;
  assign o_busy      = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames against a byte-level frame model, compared every cycle
module tb_uart_rx_frame_ctrl;
  localparam int TC = 1000;
  localparam int MI = 0, ML = 1, MP = 2, MC = 3, MO = 4;
  logic       clk = 1'b0, rst = 1'b1, rx_done = 1'b0, frm_ready = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       frm_valid, frm_last, err_pulse, busy;
  logic [7:0] frm_data;
  logic [4:0] frm_len;
  logic [2:0] err_code;
  int checks = 0, errors = 0;
  int cyc = 0, raise_cyc = 0, last_err_cyc = 0, n_err = 0, n_hs = 0;
  bit seen_valid = 0;
  logic [7:0] seq[$];
  logic [7:0] got[$];
  int         m_phase = MI, m_len = 0, m_last_acc = 0;
  bit         m_rxq = 0, m_err = 0;
  logic [2:0] m_code = 3'd0;
  logic [7:0] m_pay[$];
  logic [7:0] m_out[$];

  uart_rx_frame_ctrl #(.HDR_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .rst(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_frm_valid(frm_valid), .i_frm_ready(frm_ready), .o_frm_data(frm_data),
    .o_frm_last(frm_last), .o_frm_len(frm_len), .o_err_pulse(err_pulse),
    .o_err_code(err_code), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input logic [2:0] c);
    m_err  = 1'b1;
    m_code = c;
  endtask

  // frame-level model: bytes collected in queues, checksum folded at the end, timeout from cycle stamps
  task automatic model_step();
    bit acc, hs;
    logic [7:0] x;
    cyc++;
    acc   = rx_done && !m_rxq;
    m_rxq = rx_done;
    m_err = 1'b0;
    if (rst) begin
      m_phase = MI; m_len = 0; m_code = 3'd0; m_rxq = 1'b0;
      m_pay.delete(); m_out.delete();
      return;
    end
    hs = (m_out.size() != 0) && frm_ready;
    if (!acc && m_phase inside {ML, MP, MC} && cyc - m_last_acc == TC - 1) begin
      flag(3'd3); m_phase = MI;
    end else begin
      case (m_phase)
        MI: if (acc && rx_data == 8'hA5) m_phase = ML;
        ML: if (acc) begin
          if (rx_data == 0 || rx_data > 16) begin flag(3'd1); m_phase = MI; end
          else begin m_len = int'(rx_data); m_pay.delete(); m_phase = MP; end
        end
        MP: if (acc) begin
          m_pay.push_back(rx_data);
          if (m_pay.size() == m_len) m_phase = MC;
        end
        MC: if (acc) begin
          x = 8'(m_len);
          foreach (m_pay[i]) x ^= m_pay[i];
          if (rx_data == x) begin m_out = m_pay; m_phase = MO; end
          else begin flag(3'd2); m_phase = MI; end
        end
        default: begin
          if (acc) flag(3'd4);
          if (hs) begin
            void'(m_out.pop_front());
            if (m_out.size() == 0) m_phase = MI;
          end
        end
      endcase
    end
    if (acc) m_last_acc = cyc;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    chk("valid", 32'(frm_valid), 32'(m_out.size() != 0));
    chk("busy", 32'(busy), 32'(m_phase != MI));
    chk("err_pulse", 32'(err_pulse), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    if (m_out.size() != 0) begin
      chk("data", 32'(frm_data), 32'(m_out[0]));
      chk("last", 32'(frm_last), 32'(m_out.size() == 1));
      chk("len", 32'(frm_len), 32'(m_len));
    end
    if (err_pulse) begin n_err++; last_err_cyc = cyc; end
    if (frm_valid) seen_valid = 1'b1;
    if (frm_valid && frm_ready) n_hs++;
  end

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    rx_data   = b;
    rx_done   = 1'b1;
    raise_cyc = cyc;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_seq(input int hold, input int gap);
    foreach (seq[i]) send(seq[i], hold, gap);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(frm_valid), 0);
    chk("rst last", 32'(frm_last), 0);
    chk("rst err_pulse", 32'(err_pulse), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst data", 32'(frm_data), 0);
    chk("rst len", 32'(frm_len), 0);
    chk("rst err_code", 32'(err_code), 0);
    rst = 1'b0;
    @(negedge clk);
    // 1: good frame, csum 03^11^22^33 = 03
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_seq(1, 1);
    send(8'h03, 1, 0);
    chk("t1 v0", 32'(frm_valid), 1);
    chk("t1 d0", 32'(frm_data), 32'h11);
    chk("t1 len", 32'(frm_len), 3);
    chk("t1 l0", 32'(frm_last), 0);
    @(negedge clk);
    chk("t1 d1", 32'(frm_data), 32'h22);
    @(negedge clk);
    chk("t1 d2", 32'(frm_data), 32'h33);
    chk("t1 l2", 32'(frm_last), 1);
    @(negedge clk);
    chk("t1 done", 32'(frm_valid), 0);
    chk("t1 idle", 32'(busy), 0);
    chk("t1 no err", 32'(n_err), 0);
    // 2: wrong checksum
    seen_valid = 1'b0;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_seq(1, 1);
    repeat (3) @(negedge clk);
    chk("t2 err count", 32'(n_err), 1);
    chk("t2 code", 32'(err_code), 2);
    chk("t2 no valid", 32'(seen_valid), 0);
    chk("t2 idle", 32'(busy), 0);
    // 3: illegal lengths then a good one-byte frame (csum 01^7E = 7F)
    seq = '{8'hA5, 8'h00};
    send_seq(1, 2);
    chk("t3 code0", 32'(err_code), 1);
    chk("t3 idle0", 32'(busy), 0);
    seq = '{8'hA5, 8'h11};
    send_seq(1, 2);
    chk("t3 code17", 32'(err_code), 1);
    chk("t3 err count", 32'(n_err), 3);
    seq = '{8'hA5, 8'h01, 8'h7E};
    send_seq(1, 1);
    send(8'h7F, 1, 0);
    chk("t3 valid", 32'(frm_valid), 1);
    chk("t3 data", 32'(frm_data), 32'h7E);
    chk("t3 last", 32'(frm_last), 1);
    chk("t3 len", 32'(frm_len), 1);
    repeat (2) @(negedge clk);
    // 4: timeout after AA
    e0 = n_err;
    seq = '{8'hA5, 8'h02, 8'hAA};
    send_seq(1, 1);
    repeat (TC + 10) @(negedge clk);
    chk("t4 err count", 32'(n_err - e0), 1);
    chk("t4 code", 32'(err_code), 3);
    chk("t4 latency", 32'(last_err_cyc - raise_cyc), 32'(TC));
    seq = '{8'hA5, 8'h02, 8'h01, 8'h02};
    send_seq(1, 1);
    send(8'h01, 1, 0);
    chk("t4 recover", 32'(frm_data), 32'h01);
    repeat (3) @(negedge clk);
    // 5: stalled output, overrun byte, toggling ready
    frm_ready = 1'b0;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_seq(1, 1);
    send(8'h03, 1, 0);
    e0 = n_err;
    for (int i = 0; i < 8; i++) begin
      chk("t5 hold", 32'({frm_valid, frm_data}), 32'h111);
      @(negedge clk);
    end
    send(8'h55, 1, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t5 hold2", 32'({frm_valid, frm_data}), 32'h111);
      @(negedge clk);
    end
    chk("t5 code", 32'(err_code), 4);
    chk("t5 err count", 32'(n_err - e0), 1);
    chk("t5 len", 32'(frm_len), 3);
    got.delete();
    for (int i = 0; i < 40 && got.size() < 3; i++) begin
      frm_ready = i[0];
      if (frm_valid && frm_ready) got.push_back(frm_data);
      @(negedge clk);
    end
    frm_ready = 1'b1;
    chk("t5 count", 32'(got.size()), 3);
    if (got.size() == 3) begin
      chk("t5 b0", 32'(got[0]), 32'h11);
      chk("t5 b1", 32'(got[1]), 32'h22);
      chk("t5 b2", 32'(got[2]), 32'h33);
    end
    repeat (2) @(negedge clk);
    chk("t5 idle", 32'(busy), 0);
    // 6: long rx_done, junk before header, then reset mid-payload
    e0 = n_err;
    n_hs = 0;
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq(8, 3);
    repeat (3) @(negedge clk);
    chk("t6 delivered", 32'(n_hs), 3);
    chk("t6 no err", 32'(n_err - e0), 0);
    seen_valid = 1'b0;
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_seq(2, 2);
    chk("t6 busy pre", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst busy", 32'(busy), 0);
    chk("t6 rst valid", 32'(frm_valid), 0);
    rst = 1'b0;
    seq = '{8'h03, 8'h04, 8'h04};
    send_seq(2, 2);
    repeat (10) @(negedge clk);
    chk("t6 no output", 32'(seen_valid), 0);
    chk("t6 idle", 32'(busy), 0);
    chk("t6 err cleared", 32'(err_code), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
